cache_fill_arbiter: RTL

//  Shares the single multicycle main memory between I-cache and D-cache miss paths and D-cache write-through stores.
//  On a miss it streams the 8-word (16 B) block from memory into the requesting cache's data array, then writes its tag/meta entry.

---
 rtl/cache_fill_arbiter_pkg.sv | 36 +++
 rtl/cache_fill_arbiter_if.sv | 33 +++
 rtl/cache_fill_arbiter_fill_word_counter.sv | 45 ++++
 rtl/cache_fill_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cache_fill_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cache_fill_arbiter_pkg
// Shared constants and types for the cache fill arbiter: address geometry,
// block size, FSM state and fill-owner encodings, and the helper that builds
// a word byte-address from a block base and a word counter.
// Byte-address fields: [0] byte in word, [3:1] word offset, [9:4] index,
// [15:10] tag. The block base is everything above the word offset.
// -----------------------------------------------------------------------------
package cache_fill_arbiter_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int BLK_WORDS = 8;
  localparam int CNT_W     = $clog2(BLK_WORDS);
  localparam int OFF_LSB   = 1;
  localparam int BASE_LSB  = OFF_LSB + CNT_W;
  localparam int BASE_W    = ADDR_W - BASE_LSB;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_FILL  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [BASE_W-1:0] base,
                                                  input logic [CNT_W-1:0]  cnt);
    return {base, cnt, {OFF_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_fill_arbiter_if
// Main-memory bus between the fill arbiter (master) and the pipelined memory
// model (slave). Reads return mem_rdata with mem_valid a fixed number of cycles
// after the mem_en strobe; writes complete in the strobe cycle.
//   mem_en    master->slave  access strobe
//   mem_wr    master->slave  1 = write, 0 = read (qualified by mem_en)
//   mem_addr  master->slave  byte address
//   mem_wdata master->slave  write data
//   mem_rdata slave->master  read data
//   mem_valid slave->master  read data valid
// -----------------------------------------------------------------------------
interface cache_fill_arbiter_if;
  import cache_fill_arbiter_pkg::*;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_valid
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_valid
  );

endinterface

// File: rtl/cache_fill_arbiter_fill_word_counter.sv
// -----------------------------------------------------------------------------
// cache_fill_arbiter_fill_word_counter
// Word counter for one direction of a block fill (issued reads or received
// beats). Wraps naturally at BLK_WORDS.
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       force count to 0 (wins over inc)
//   inc         advance count by one
//   count       current word index
//   last        count is the final word of the block
// -----------------------------------------------------------------------------
module cache_fill_arbiter_fill_word_counter
  import cache_fill_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CNT_W'(BLK_WORDS - 1));

endmodule

// File: rtl/cache_fill_arbiter.sv
// -----------------------------------------------------------------------------
// cache_fill_arbiter
// Shares one pipelined main memory between I-cache misses, D-cache misses and
// D-cache write-through stores. A miss streams the whole block from memory into
// the owning cache's data array and writes the tag with the final word, which
// is what releases the cache's stall.
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_miss, i_miss_addr         I-cache miss request (level) and byte address
//   d_miss, d_miss_addr         D-cache miss request (level) and byte address
//   d_wr_req/addr/data, d_wr_ack  store request (level) and one-cycle issue ack
//   mem                         memory bus (master side)
//   fill_addr, fill_data        word address / data presented to the caches
//   {i,d}_fill_data_we          data-array word write enables (owner only)
//   {i,d}_fill_tag_we           tag write enables, with the last fill word
//   busy                        a store or fill is in progress
// IDLE priority: store, then D miss, then I miss. Every store/fill returns to
// IDLE for at least one cycle so the cache can drop its request after the hit.
// -----------------------------------------------------------------------------
module cache_fill_arbiter
  import cache_fill_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_miss,
  input  logic [ADDR_W-1:0]    i_miss_addr,
  input  logic                 d_miss,
  input  logic [ADDR_W-1:0]    d_miss_addr,
  input  logic                 d_wr_req,
  input  logic [ADDR_W-1:0]    d_wr_addr,
  input  logic [DATA_W-1:0]    d_wr_data,
  output logic                 d_wr_ack,
  cache_fill_arbiter_if.master mem,
  output logic [ADDR_W-1:0]    fill_addr,
  output logic [DATA_W-1:0]    fill_data,
  output logic                 i_fill_data_we,
  output logic                 i_fill_tag_we,
  output logic                 d_fill_data_we,
  output logic                 d_fill_tag_we,
  output logic                 busy
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              issue_done_q, issue_done_d;
  logic [BASE_W-1:0] blk_base_q, blk_base_d;

  logic              grant;
  logic              issue_inc, issue_last;
  logic [CNT_W-1:0]  issue_cnt;
  logic              recv_inc, recv_last;
  logic [CNT_W-1:0]  recv_cnt;

  // Word-offset bits of the miss addresses are irrelevant: fills start at word 0.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{i_miss_addr[BASE_LSB-1:0], d_miss_addr[BASE_LSB-1:0]};

  cache_fill_arbiter_fill_word_counter u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (grant),
    .inc   (issue_inc),
    .count (issue_cnt),
    .last  (issue_last)
  );

  cache_fill_arbiter_fill_word_counter u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (grant),
    .inc   (recv_inc),
    .count (recv_cnt),
    .last  (recv_last)
  );

  assign fill_data = mem.mem_rdata;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    issue_done_d   = issue_done_q;
    blk_base_d     = blk_base_q;
    grant          = 1'b0;
    issue_inc      = 1'b0;
    recv_inc       = 1'b0;
    mem.mem_en     = 1'b0;
    mem.mem_wr     = 1'b0;
    mem.mem_addr   = '0;
    mem.mem_wdata  = '0;
    d_wr_ack       = 1'b0;
    fill_addr      = '0;
    i_fill_data_we = 1'b0;
    i_fill_tag_we  = 1'b0;
    d_fill_data_we = 1'b0;
    d_fill_tag_we  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (d_wr_req) begin
          state_d = ST_STORE;
        end else if (d_miss) begin
          grant      = 1'b1;
          owner_d    = OWN_D;
          blk_base_d = d_miss_addr[ADDR_W-1:BASE_LSB];
          state_d    = ST_FILL;
        end else if (i_miss) begin
          grant      = 1'b1;
          owner_d    = OWN_I;
          blk_base_d = i_miss_addr[ADDR_W-1:BASE_LSB];
          state_d    = ST_FILL;
        end
      end

      ST_STORE: begin
        mem.mem_en    = 1'b1;
        mem.mem_wr    = 1'b1;
        mem.mem_addr  = d_wr_addr;
        mem.mem_wdata = d_wr_data;
        d_wr_ack      = 1'b1;
        state_d       = ST_IDLE;
      end

      ST_FILL: begin
        // issue_cnt wraps to 0 after the last read, so a separate flag stops issue.
        if (!issue_done_q) begin
          mem.mem_en   = 1'b1;
          mem.mem_addr = word_addr(blk_base_q, issue_cnt);
          issue_inc    = 1'b1;
          if (issue_last) begin
            issue_done_d = 1'b1;
          end
        end
        fill_addr = word_addr(blk_base_q, recv_cnt);
        if (mem.mem_valid) begin
          recv_inc       = 1'b1;
          i_fill_data_we = (owner_q == OWN_I);
          d_fill_data_we = (owner_q == OWN_D);
          // Tag goes in with the final word so the cache hits on the next cycle.
          if (recv_last) begin
            i_fill_tag_we = (owner_q == OWN_I);
            d_fill_tag_we = (owner_q == OWN_D);
            owner_d       = OWN_NONE;
            state_d       = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (grant) begin
      issue_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      issue_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      issue_done_q <= issue_done_d;
    end
  end

  // Block base is only observed in FILL, after a grant has loaded it.
  always_ff @(posedge clk) begin
    blk_base_q <= blk_base_d;
  end

endmodule
